// File: rtl/fifo_access_ctrl_pkg.sv
// Shared definitions for the FIFO access controller: per-cycle operation
// encoding (also used to remember the last granted operation) and op selection.
package fifo_access_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // Under contention the side that did not go last wins, so neither starves.
  function automatic op_e pick_op(input logic wr_cand, input logic rd_cand,
                                  input op_e last_op);
    if (wr_cand && rd_cand) return (last_op == OP_WRITE) ? OP_READ : OP_WRITE;
    if (wr_cand)            return OP_WRITE;
    if (rd_cand)            return OP_READ;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/fifo_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// rr_ptr, wrapping around. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter  int kReqNum = 2,
  localparam int kIdxW   = $clog2(kReqNum)
) (
  input  logic [kReqNum-1:0] req,
  input  logic [kIdxW-1:0]   rr_ptr,
  output logic [kReqNum-1:0] grant,
  output logic [kIdxW-1:0]   grant_idx,
  output logic               any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 0; i < kReqNum; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= kReqNum) j = j - kReqNum;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant_idx = kIdxW'(j);
        grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Sequences one shared FIFO: each cycle grants exactly one of a round-robin
// arbitrated WRITE, a valid/ready READ, or IDLE.
module fifo_access_ctrl
  import fifo_access_ctrl_pkg::*;
#(
  parameter int kWidth     = 32,
  parameter int kAddrWidth = 4,
  parameter int kReqNum    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [kReqNum-1:0]        req_valid,
  input  logic [kReqNum*kWidth-1:0] req_data,
  output logic [kReqNum-1:0]        req_ready,
  input  logic                      deq_ready,
  output logic                      deq_valid,
  output logic [kWidth-1:0]         deq_data,
  output logic [kAddrWidth:0]       count,
  output logic                      fifo_flush,
  output logic                      fifo_write_en,
  output logic [kWidth-1:0]         fifo_write_data,
  output logic                      fifo_read_en,
  input  logic [kWidth-1:0]         fifo_read_data,
  input  logic                      fifo_is_full,
  input  logic                      fifo_is_empty
);

  localparam int kIdxW = $clog2(kReqNum);

  logic [kIdxW-1:0]   rr_ptr_q, rr_ptr_d;
  op_e                last_op_q, last_op_d;
  logic [kAddrWidth:0] count_q, count_d;

  logic [kReqNum-1:0] grant;
  logic [kIdxW-1:0]   grant_idx;
  logic               arb_any;
  logic               wr_cand, rd_cand;
  op_e                op;

  rr_arbiter #(.kReqNum(kReqNum)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (arb_any)
  );

  // Reset and flush both suppress every grant.
  always_comb begin
    wr_cand = arb_any && !fifo_is_full;
    rd_cand = deq_ready && !fifo_is_empty;
    op      = OP_IDLE;
    if (rst && !flush) op = pick_op(wr_cand, rd_cand, last_op_q);
  end

  always_comb begin
    fifo_flush      = rst && flush;
    fifo_write_en   = (op == OP_WRITE);
    req_ready       = fifo_write_en ? grant : '0;
    fifo_write_data = fifo_write_en ? req_data[grant_idx*kWidth +: kWidth] : '0;
    fifo_read_en    = (op == OP_READ);
    deq_valid       = fifo_read_en;
    deq_data        = fifo_read_en ? fifo_read_data : '0;
    count           = count_q;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    last_op_d = last_op_q;
    count_d   = count_q;
    if (flush) begin
      rr_ptr_d  = '0;
      last_op_d = OP_READ;
      count_d   = '0;
    end else if (op == OP_WRITE) begin
      rr_ptr_d  = (grant_idx == kIdxW'(kReqNum - 1)) ? '0 : grant_idx + 1'b1;
      last_op_d = OP_WRITE;
      count_d   = count_q + 1'b1;
    end else if (op == OP_READ) begin
      last_op_d = OP_READ;
      count_d   = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      last_op_q <= OP_READ;
      count_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      last_op_q <= last_op_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl with a behavioural 16-deep FIFO attached.
module tb_fifo_access_ctrl;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int RN = 2;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [RN-1:0] req_valid;
  logic [W-1:0]  data0, data1;
  logic [RN-1:0] req_ready;
  logic          deq_ready, deq_valid;
  logic [W-1:0]  deq_data;
  logic [AW:0]   count;
  logic          fifo_flush, fifo_write_en, fifo_read_en;
  logic [W-1:0]  fifo_write_data, fifo_read_data;
  logic          fifo_is_full, fifo_is_empty;

  always #5 clk = ~clk;

  fifo_access_ctrl #(.kWidth(W), .kAddrWidth(AW), .kReqNum(RN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_data({data1, data0}), .req_ready(req_ready),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
    .count(count), .fifo_flush(fifo_flush),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
    .fifo_is_full(fifo_is_full), .fifo_is_empty(fifo_is_empty)
  );

  // Behavioural FIFO environment
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   fcnt;

  always_ff @(posedge clk) begin
    if (!rst || fifo_flush) begin
      wp <= '0; rp <= '0; fcnt <= '0;
    end else if (fifo_write_en) begin
      mem[wp] <= fifo_write_data; wp <= wp + 1'b1; fcnt <= fcnt + 1'b1;
    end else if (fifo_read_en) begin
      rp <= rp + 1'b1; fcnt <= fcnt - 1'b1;
    end
  end

  assign fifo_read_data = fifo_read_en ? mem[rp] : '0;
  assign fifo_is_full   = (fcnt == (AW+1)'(DEPTH));
  assign fifo_is_empty  = (fcnt == '0);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_wd [4];
  logic [RN-1:0] exp_rr [4];
  logic [W-1:0] exp_rd [3];

  initial begin
    exp_wd = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd = '{32'hA1, 32'hB1, 32'hC0};

    rst = 1'b0; flush = 1'b0; req_valid = 2'b11; data0 = 32'h1; data1 = 32'h2; deq_ready = 1'b0;
    step();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_write_en", fifo_write_en, 0);
    check("rst_count", count, 0);
    flush = 1'b1; deq_ready = 1'b1;
    #1;
    check("rst_flush_out", fifo_flush, 0);
    check("rst_deq_valid", deq_valid, 0);
    step();
    check("rst_count2", count, 0);

    // Round-robin writes
    rst = 1'b1; flush = 1'b0; deq_ready = 1'b0; req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      data0 = 32'hA0 + n/2; data1 = 32'hB0 + n/2;
      #1;
      check($sformatf("rr_ready%0d", n), req_ready, exp_rr[n]);
      check($sformatf("rr_wdata%0d", n), fifo_write_data, exp_wd[n]);
      step();
    end
    check("rr_count", count, 4);

    // Two reads down to 2, then one write of C0 so last_op is WRITE with 3 held
    req_valid = 2'b00; deq_ready = 1'b1;
    #1; check("pre_rd0", deq_data, 32'hA0); step();
    #1; check("pre_rd1", deq_data, 32'hB0); step();
    req_valid = 2'b01; data0 = 32'hC0; deq_ready = 1'b0;
    #1; check("pre_wr", req_ready, 2'b01); step();
    check("pre_count", count, 3);

    // Contention: R,W,R,W,R,W
    deq_ready = 1'b1; req_valid = 2'b01;
    for (int k = 0; k < 6; k++) begin
      data0 = 32'hD0 + k;
      #1;
      check($sformatf("alt_ren%0d", k), fifo_read_en, (k % 2 == 0));
      check($sformatf("alt_wen%0d", k), fifo_write_en, (k % 2 == 1));
      check($sformatf("alt_excl%0d", k), fifo_read_en && fifo_write_en, 0);
      check($sformatf("alt_cnt%0d", k), count, (k % 2 == 0) ? 3 : 2);
      if (k % 2 == 0) check($sformatf("alt_rd%0d", k), deq_data, exp_rd[k/2]);
      else            check($sformatf("alt_ready%0d", k), req_ready, 2'b01);
      step();
    end
    check("alt_count", count, 3);

    // Fill to full
    deq_ready = 1'b0; req_valid = 2'b11;
    for (int k = 0; k < 13; k++) begin
      data0 = 32'h100 + k; data1 = 32'h200 + k;
      step();
    end
    check("full_count", count, 16);
    #1;
    check("full_ready", req_ready, 0);
    check("full_wen", fifo_write_en, 0);
    deq_ready = 1'b1;
    #1;
    check("full_deq_valid", deq_valid, 1);
    check("full_deq_data", deq_data, 32'hD1);
    step();
    check("full_count2", count, 15);

    // Drain
    req_valid = 2'b00;
    for (int k = 0; k < 15; k++) step();
    check("drain_count", count, 0);

    // Empty
    #1;
    check("empty_deq_valid", deq_valid, 0);
    check("empty_ren", fifo_read_en, 0);
    req_valid = 2'b01; data0 = 32'h55;
    #1;
    check("empty_wen", fifo_write_en, 1);
    step();
    req_valid = 2'b00;
    #1;
    check("empty_deq_valid2", deq_valid, 1);
    check("empty_deq_data", deq_data, 32'h55);
    step();
    check("empty_count", count, 0);

    // Flush mid-traffic
    deq_ready = 1'b0; req_valid = 2'b11;
    for (int k = 0; k < 5; k++) step();
    check("fl_count", count, 5);
    flush = 1'b1; req_valid = 2'b10; deq_ready = 1'b1;
    #1;
    check("fl_flush_out", fifo_flush, 1);
    check("fl_ready", req_ready, 0);
    check("fl_wen", fifo_write_en, 0);
    check("fl_ren", fifo_read_en, 0);
    check("fl_deq_valid", deq_valid, 0);
    step();
    flush = 1'b0; req_valid = 2'b11; deq_ready = 1'b0;
    #1;
    check("fl_count2", count, 0);
    check("fl_empty", fifo_is_empty, 1);
    check("fl_first_grant", req_ready, 2'b01);
    step();
    check("fl_count3", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
